// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: scoreboarded hazard stall, RF read drive, output pipeline register.
// Optional same-cycle writeback bypass enabled by defining OPERAND_FETCH_WB_BYPASS_EN.
module operand_fetch (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_instr,
   output logic        rf_cs,
   output logic        rf_rd,
   output logic [2:0]  rf_rdReg1,
   output logic [2:0]  rf_rdReg2,
   input  logic [15:0] rf_rdData1,
   input  logic [15:0] rf_rdData2,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  out_opcode,
   output logic [2:0]  out_rd,
   output logic        out_wen,
   output logic [15:0] out_op1,
   output logic [15:0] out_op2,
   input  logic        wb_valid,
   input  logic [2:0]  wb_reg,
   input  logic [15:0] wb_data,
   output logic [15:0] stall_cnt
);

   logic [3:0]  opcode;
   logic [2:0]  rd, rs1, rs2;
   logic        reads1, reads2, writes;
   logic        hazard, issue;
   logic [7:0]  busy_q, busy_d, busy_eff;
   logic [15:0] op1, op2_reg;
   logic [15:0] stall_d;

   assign opcode = in_instr[15:12];
   assign rd     = in_instr[11:9];
   assign rs1    = in_instr[8:6];
   assign rs2    = in_instr[5:3];

   assign reads1 = (opcode != 4'h0);
   assign reads2 = ((opcode != 4'h0) && (opcode <= 4'h7)) || (opcode[3:2] == 2'b11);
   assign writes = (opcode != 4'h0) && (opcode <= 4'hB);

   assign rf_cs     = in_valid;
   assign rf_rd     = in_valid;
   assign rf_rdReg1 = rs1;
   assign rf_rdReg2 = rs2;

`ifdef OPERAND_FETCH_WB_BYPASS_EN
   // A writeback landing this cycle unblocks its register and forwards its data.
   assign busy_eff = busy_q & ~(wb_valid ? (8'b1 << wb_reg) : 8'b0);
   assign op1      = (wb_valid && wb_reg == rs1) ? wb_data : rf_rdData1;
   assign op2_reg  = (wb_valid && wb_reg == rs2) ? wb_data : rf_rdData2;
`else
   logic unused_wb_data;
   assign unused_wb_data = ^wb_data;
   assign busy_eff = busy_q;
   assign op1      = rf_rdData1;
   assign op2_reg  = rf_rdData2;
`endif

   assign hazard   = (reads1 & busy_eff[rs1]) | (reads2 & busy_eff[rs2]) | (writes & busy_eff[rd]);
   assign in_ready = !hazard && (!out_valid || out_ready);
   assign issue    = in_valid && in_ready;

   always_comb begin
      busy_d = busy_q;
      if (wb_valid) busy_d[wb_reg] = 1'b0;
      // Issue applied after writeback so a same-cycle set wins.
      if (issue && writes) busy_d[rd] = 1'b1;
   end

   always_comb begin
      stall_d = stall_cnt;
      if (in_valid && hazard && stall_cnt != 16'hFFFF) stall_d = stall_cnt + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_opcode <= 4'h0;
         out_rd     <= 3'd0;
         out_wen    <= 1'b0;
         out_op1    <= 16'h0;
         out_op2    <= 16'h0;
         busy_q     <= 8'h0;
         stall_cnt  <= 16'h0;
      end else begin
         busy_q    <= busy_d;
         stall_cnt <= stall_d;
         if (issue) begin
            out_valid  <= 1'b1;
            out_opcode <= opcode;
            out_rd     <= rd;
            out_wen    <= writes;
            out_op1    <= op1;
            out_op2    <= (opcode[3:2] == 2'b10) ? {{10{in_instr[5]}}, in_instr[5:0]} : op2_reg;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch; follows OPERAND_FETCH_WB_BYPASS_EN if defined.
module tb_operand_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_instr;
   logic        rf_cs, rf_rd;
   logic [2:0]  rf_rdReg1, rf_rdReg2;
   logic [15:0] rf_rdData1, rf_rdData2;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_opcode;
   logic [2:0]  out_rd;
   logic        out_wen;
   logic [15:0] out_op1, out_op2;
   logic        wb_valid;
   logic [2:0]  wb_reg;
   logic [15:0] wb_data;
   logic [15:0] stall_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   operand_fetch dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .rf_cs      (rf_cs),
      .rf_rd      (rf_rd),
      .rf_rdReg1  (rf_rdReg1),
      .rf_rdReg2  (rf_rdReg2),
      .rf_rdData1 (rf_rdData1),
      .rf_rdData2 (rf_rdData2),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_opcode (out_opcode),
      .out_rd     (out_rd),
      .out_wen    (out_wen),
      .out_op1    (out_op1),
      .out_op2    (out_op2),
      .wb_valid   (wb_valid),
      .wb_reg     (wb_reg),
      .wb_data    (wb_data),
      .stall_cnt  (stall_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_instr = 16'h0; out_ready = 1'b1;
      rf_rdData1 = 16'h0; rf_rdData2 = 16'h0;
      wb_valid = 1'b0; wb_reg = 3'd0; wb_data = 16'h0;
      step(); step();
      rst = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_checks++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_stall got %h want 0000", stall_cnt); end
      n_checks++; if (out_op1 !== 16'h0 || out_wen !== 1'b0) begin n_fail++; $display("FAIL reset_payload got op1=%h wen=%b want 0", out_op1, out_wen); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_rtype();
      in_valid = 1'b1; in_instr = 16'h1298; rf_rdData1 = 16'h0011; rf_rdData2 = 16'h0022;
      #1;
      n_checks++; if (rf_rdReg1 !== 3'd2 || rf_rdReg2 !== 3'd3 || rf_cs !== 1'b1 || rf_rd !== 1'b1) begin
         n_fail++; $display("FAIL rtype_rf got r1=%0d r2=%0d cs=%b rd=%b want 2 3 1 1", rf_rdReg1, rf_rdReg2, rf_cs, rf_rd); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rtype_ready got %b want 1", in_ready); end
      step();
      n_checks++; if (out_valid !== 1'b1 || out_rd !== 3'd1 || out_wen !== 1'b1 || out_opcode !== 4'h1) begin
         n_fail++; $display("FAIL rtype_out got v=%b rd=%0d wen=%b opc=%h want 1 1 1 1", out_valid, out_rd, out_wen, out_opcode); end
      n_checks++; if (out_op1 !== 16'h0011 || out_op2 !== 16'h0022) begin
         n_fail++; $display("FAIL rtype_ops got %h %h want 0011 0022", out_op1, out_op2); end
   endtask

   // 16'h1850: rd=4, rs1=1 (busy from 16'h1298), rs2=2.
   task automatic test_raw_stall();
      in_instr = 16'h1850; rf_rdData1 = 16'hAAAA; rf_rdData2 = 16'hBBBB;
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_blocked got %b want 0", in_ready); end
      step();
      n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL raw_stall1 got %0d want 1", stall_cnt); end
      step();
      n_checks++; if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL raw_stall2 got %0d want 2", stall_cnt); end
      wb_valid = 1'b1; wb_reg = 3'd1; wb_data = 16'h1234;
      #1;
`ifdef OPERAND_FETCH_WB_BYPASS_EN
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_bypass_ready got %b want 1", in_ready); end
      step();
      wb_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1 || out_rd !== 3'd4 || out_op1 !== 16'h1234 || out_op2 !== 16'hBBBB) begin
         n_fail++; $display("FAIL raw_issue got v=%b rd=%0d op1=%h op2=%h want 1 4 1234 bbbb", out_valid, out_rd, out_op1, out_op2); end
      n_checks++; if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL raw_stall_final got %0d want 2", stall_cnt); end
`else
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_wb_cycle_ready got %b want 0", in_ready); end
      step();
      wb_valid = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_after_wb_ready got %b want 1", in_ready); end
      step();
      n_checks++; if (out_valid !== 1'b1 || out_rd !== 3'd4 || out_op1 !== 16'hAAAA || out_op2 !== 16'hBBBB) begin
         n_fail++; $display("FAIL raw_issue got v=%b rd=%0d op1=%h op2=%h want 1 4 aaaa bbbb", out_valid, out_rd, out_op1, out_op2); end
      n_checks++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL raw_stall_final got %0d want 3", stall_cnt); end
`endif
      in_valid = 1'b0;
   endtask

   task automatic test_itype();
      in_valid = 1'b1; in_instr = 16'h8BBE; rf_rdData1 = 16'h0066; rf_rdData2 = 16'h7777;
      #1;
      n_checks++; if (rf_rdReg1 !== 3'd6 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL itype_rf got r1=%0d ready=%b want 6 1", rf_rdReg1, in_ready); end
      step();
      in_valid = 1'b0;
      n_checks++; if (out_op2 !== 16'hFFFE || out_op1 !== 16'h0066 || out_wen !== 1'b1 || out_rd !== 3'd5) begin
         n_fail++; $display("FAIL itype_out got op1=%h op2=%h wen=%b rd=%0d want 0066 fffe 1 5", out_op1, out_op2, out_wen, out_rd); end
   endtask

   task automatic test_back_to_back();
      in_valid = 1'b1; in_instr = 16'h3E49;
      step();
      n_checks++; if (out_opcode !== 4'h3 || out_rd !== 3'd7 || out_valid !== 1'b1) begin
         n_fail++; $display("FAIL b2b_first got opc=%h rd=%0d v=%b want 3 7 1", out_opcode, out_rd, out_valid); end
      in_instr = 16'hC000;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b want 1", in_ready); end
      step();
      n_checks++; if (out_opcode !== 4'hC || out_wen !== 1'b0 || out_valid !== 1'b1) begin
         n_fail++; $display("FAIL b2b_second got opc=%h wen=%b v=%b want c 0 1", out_opcode, out_wen, out_valid); end
   endtask

   task automatic test_backpressure();
      logic [15:0] s0;
      s0 = stall_cnt;
      in_instr = 16'h0000; out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got %b want 0", i, in_ready); end
         step();
         n_checks++; if (out_valid !== 1'b1 || out_opcode !== 4'hC || stall_cnt !== s0) begin
            n_fail++; $display("FAIL bp_hold[%0d] got v=%b opc=%h stall=%0d want 1 c %0d", i, out_valid, out_opcode, stall_cnt, s0); end
      end
      out_ready = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got %b want 1", in_ready); end
      step();
      in_valid = 1'b0;
      n_checks++; if (out_opcode !== 4'h0 || out_wen !== 1'b0) begin
         n_fail++; $display("FAIL bp_nop got opc=%h wen=%b want 0 0", out_opcode, out_wen); end
   endtask

   task automatic test_set_wins();
      in_valid = 1'b1; in_instr = 16'h1600; wb_valid = 1'b1; wb_reg = 3'd3;
      step();
      wb_valid = 1'b0; in_instr = 16'hC0C0;
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL set_wins got ready=%b want 0", in_ready); end
   endtask

   task automatic test_saturation_reset();
      logic [15:0] s0;
      for (int i = 0; i < 70000; i++) step();
      n_checks++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat got %h want ffff", stall_cnt); end
      step();
      n_checks++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h want ffff", stall_cnt); end
      in_instr = 16'h0000; out_ready = 1'b0;
      step();
      s0 = stall_cnt;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_rst_valid got %b want 1", out_valid); end
      in_instr = 16'hC0C0; rst = 1'b1; wb_valid = 1'b1; wb_reg = 3'd3;
      step();
      rst = 1'b0; wb_valid = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0 || stall_cnt !== 16'h0 || out_opcode !== 4'h0) begin
         n_fail++; $display("FAIL rst_mid got v=%b stall=%h opc=%h (before %h) want 0 0000 0", out_valid, stall_cnt, out_opcode, s0); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_busy_clear got ready=%b want 1", in_ready); end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_raw_stall();
      test_itype();
      test_back_to_back();
      test_backpressure();
      test_set_wins();
      test_saturation_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
